data_bus_bridge: RTL and testbench

- Sits directly downstream of the MEM-stage access unit. It takes that unit's single-cycle SRAM-style port (en/wen/addr/wdata/rdata) and turns it into a valid/ready request plus response bus toward the data cache or uncached bus.
- While a transaction is in flight it stalls the pipeline.
- It registers read data until the pipeline advances.
- It handles flush and bus-timeout.

---
 rtl/data_bus_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_data_bus_bridge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: converts the MEM-stage single-cycle SRAM-style port into a
// valid/ready request bus plus a response bus. Stalls the pipeline while a
// transaction is in flight, holds read data until the pipeline advances, and
// handles pipeline flush and bus timeout. At most one transaction outstanding.
//
// Handshake semantics (request channel): req_valid rises only in REQ and,
// once high, req_write/req_strb/req_addr/req_wdata stay stable until the
// cycle in which req_valid & req_ready are both high; that cycle is the
// transfer. The response channel has no ready: resp_valid is a single-cycle
// pulse that is consumed only in WAIT (delivered) or DRAIN (discarded) and
// ignored in every other state.
module data_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // MEM-stage side
  input  logic                mem_en,
  input  logic [DATA_W/8-1:0] mem_wen,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  input  logic                addr_err,
  input  logic                flush,
  input  logic                pipe_adv,
  output logic                stall,
  output logic                bus_err,
  // Request channel
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_write,
  output logic [DATA_W/8-1:0] req_strb,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]   req_wdata,
  // Response channel
  input  logic                resp_valid,
  input  logic [DATA_W-1:0]   resp_data,
  // Debug: current FSM state (IDLE=0, REQ=1, WAIT=2, DRAIN=3, DONE=4)
  output logic [2:0]          dbg_state
);

  localparam int STRB_W = DATA_W / 8;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // design still elaborates when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                req_write_q, req_write_d;
  logic [STRB_W-1:0]   req_strb_q, req_strb_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic start;
  logic timeout_hit;

  // A new access is launched only when the MEM stage asks, the address is
  // aligned and the instruction is not being flushed.
  assign start = mem_en & ~addr_err & ~flush;

  // Counter has spent its budget in WAIT/DRAIN; never fires when disabled.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        // An accepted request must be drained even if flushed, since the
        // bus will still answer it.
        if (req_ready) begin
          state_d = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Timeout wins over flush: once the bus is declared dead there is
        // nothing left to drain.
        if (resp_valid) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (resp_valid || timeout_hit) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (pipe_adv || flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore/Mealy outputs toward the pipeline and the bus
  always_comb begin
    req_valid = 1'b0;
    stall     = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = start;
      end
      ST_REQ: begin
        req_valid = 1'b1;
        stall     = 1'b1;
      end
      ST_WAIT: begin
        stall   = 1'b1;
        bus_err = ~resp_valid & timeout_hit;
      end
      ST_DRAIN: begin
        // The flushed access is gone; only a new access has to wait.
        stall = mem_en;
      end
      ST_DONE: begin
        stall = 1'b0;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Datapath next values: request capture, read-data capture, wait counter
  always_comb begin
    req_write_d = req_write_q;
    req_strb_d  = req_strb_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_write_d = |mem_wen;
          req_strb_d  = (|mem_wen) ? mem_wen : {STRB_W{1'b1}};
          req_addr_d  = mem_addr;
          req_wdata_d = mem_wdata;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (resp_valid) begin
          rdata_d = req_write_q ? '0 : resp_data;
        end else if (timeout_hit) begin
          rdata_d = '0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_write_q <= 1'b0;
      req_strb_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      req_write_q <= req_write_d;
      req_strb_q  <= req_strb_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_write = req_write_q;
  assign req_strb  = req_strb_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign mem_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed + lightly randomised bench for data_bus_bridge (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_data_bus_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          clk;
  logic          rst;
  logic          mem_en;
  logic [SW-1:0] mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          addr_err;
  logic          flush;
  logic          pipe_adv;
  logic          stall;
  logic          bus_err;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [SW-1:0] req_strb;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic [2:0]    dbg_state;

  data_bus_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .addr_err(addr_err), .flush(flush), .pipe_adv(pipe_adv),
    .stall(stall), .bus_err(bus_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected mem_rdata per completed access
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0;
    addr_err = 1'b0; flush = 1'b0; pipe_adv = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
  endtask

  // Drive one complete access (starting in IDLE) and check every phase.
  task automatic run_access(input logic [AW-1:0] addr, input logic [SW-1:0] wen,
                            input logic [DW-1:0] wdata, input int rdy_dly,
                            input int resp_dly, input logic [DW-1:0] rdata);
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] got;
    logic [SW-1:0] exp_strb;
    exp_strb = (wen == '0) ? {SW{1'b1}} : wen;
    exp_rd   = (wen == '0) ? rdata : '0;
    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
    @(negedge clk);
    chk("acc_idle_stall", 32'(stall), 32'd1);
    chk("acc_idle_valid", 32'(req_valid), 32'd0);
    exp_q.push_back(exp_rd);
    last_rdata = exp_rd;
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      req_ready = (i == rdy_dly);
      @(negedge clk);
      chk("acc_req_valid", 32'(req_valid), 32'd1);
      chk("acc_req_write", 32'(req_write), 32'(wen != '0));
      chk("acc_req_strb", 32'(req_strb), 32'(exp_strb));
      chk("acc_req_addr", req_addr, addr);
      chk("acc_req_wdata", req_wdata, wdata);
      chk("acc_req_stall", 32'(stall), 32'd1);
      tick();
    end
    req_ready = 1'b0;
    for (int i = 0; i <= resp_dly; i++) begin
      resp_valid = (i == resp_dly);
      resp_data  = (i == resp_dly) ? rdata : DW'($urandom);
      @(negedge clk);
      chk("acc_wait_valid", 32'(req_valid), 32'd0);
      chk("acc_wait_stall", 32'(stall), 32'd1);
      chk("acc_wait_buserr", 32'(bus_err), 32'd0);
      tick();
    end
    resp_valid = 1'b0;
    pipe_adv = 1'b1;
    @(negedge clk);
    chk("acc_done_state", 32'(dbg_state), 32'(S_DONE));
    chk("acc_done_stall", 32'(stall), 32'd0);
    got = exp_q.pop_front();
    chk("acc_done_rdata", mem_rdata, got);
    tick();
    pipe_adv = 1'b0; mem_en = 1'b0; mem_wen = '0;
    @(negedge clk);
    chk("acc_back_idle", 32'(dbg_state), 32'(S_IDLE));
    tick();
  endtask

  int pulses;

  initial begin
    idle_inputs();
    last_rdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_write", 32'(req_write), 32'd0);
    chk("rst_strb", 32'(req_strb), 32'd0);
    chk("rst_addr", req_addr, 32'd0);
    chk("rst_wdata", req_wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    tick();

    // Read on a zero-wait bus
    run_access(32'h1000_0004, 4'b0000, 32'h0, 0, 0, 32'hDEAD_BEEF);

    // Byte write with three cycles of backpressure
    run_access(32'h2000_0008, 4'b0100, 32'h5A5A_5A5A, 3, 0, 32'h0BAD_0BAD);

    // Misaligned access never reaches the bus
    mem_en = 1'b1; addr_err = 1'b1; mem_addr = 32'h2000_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aerr_valid", 32'(req_valid), 32'd0);
      chk("aerr_stall", 32'(stall), 32'd0);
      chk("aerr_state", 32'(dbg_state), 32'(S_IDLE));
      tick();
    end
    mem_en = 1'b0; addr_err = 1'b0;

    // Flush in REQ before acceptance: request withdrawn
    mem_en = 1'b1; mem_wen = '0; mem_addr = 32'h3000_0000;
    @(negedge clk);
    chk("frq_stall", 32'(stall), 32'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("frq_valid", 32'(req_valid), 32'd1);
    tick();
    flush = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    chk("frq_state", 32'(dbg_state), 32'(S_IDLE));
    chk("frq_valid_off", 32'(req_valid), 32'd0);
    chk("frq_stall_off", 32'(stall), 32'd0);
    tick();

    // Flush in WAIT: drain the late response, hold off the next access
    mem_en = 1'b1; mem_addr = 32'h3000_0010;
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fw_state_wait", 32'(dbg_state), 32'(S_WAIT));
    tick();
    flush = 1'b0; mem_en = 1'b1; mem_addr = 32'h4000_0000;
    @(negedge clk);
    chk("fw_state_drain", 32'(dbg_state), 32'(S_DRAIN));
    chk("fw_drain_stall", 32'(stall), 32'd1);
    chk("fw_drain_valid", 32'(req_valid), 32'd0);
    tick();
    resp_valid = 1'b1; resp_data = 32'h0000_1234;
    @(negedge clk);
    chk("fw_drain_hold", 32'(dbg_state), 32'(S_DRAIN));
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    chk("fw_after_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("fw_rdata_kept", mem_rdata, last_rdata);
    chk("fw_new_stall", 32'(stall), 32'd1);
    tick();
    req_ready = 1'b1;
    @(negedge clk);
    chk("fw_new_valid", 32'(req_valid), 32'd1);
    chk("fw_new_addr", req_addr, 32'h4000_0000);
    tick();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    last_rdata = 32'hA5A5_0001;
    tick();
    resp_valid = 1'b0; pipe_adv = 1'b1;
    @(negedge clk);
    chk("fw_new_rdata", mem_rdata, exp_q.pop_front());
    tick();
    pipe_adv = 1'b0; mem_en = 1'b0;

    // Timeout: no response ever arrives
    mem_en = 1'b1; mem_addr = 32'h6000_0000;
    tick();
    req_ready = 1'b1;
    @(negedge clk);
    chk("to_accept", 32'(req_valid), 32'd1);
    tick();
    req_ready = 1'b0;
    pulses = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_wait_state", 32'(dbg_state), 32'(S_WAIT));
      chk("to_buserr", 32'(bus_err), 32'(k == TO - 1));
      if (bus_err === 1'b1) pulses++;
      tick();
    end
    last_rdata = '0;
    @(negedge clk);
    chk("to_done_state", 32'(dbg_state), 32'(S_DONE));
    chk("to_done_rdata", mem_rdata, 32'd0);
    chk("to_done_stall", 32'(stall), 32'd0);
    if (bus_err === 1'b1) pulses++;
    tick();
    pipe_adv = 1'b1;
    @(negedge clk);
    if (bus_err === 1'b1) pulses++;
    chk("to_pulse_count", 32'(pulses), 32'd1);
    tick();
    pipe_adv = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    chk("to_idle", 32'(dbg_state), 32'(S_IDLE));
    tick();

    // Reset in the middle of a write
    run_access(32'h7000_0000, 4'b0000, 32'h0, 1, 2, 32'h7766_5544);
    mem_en = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h5000_0010; mem_wdata = 32'h1122_3344;
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rw_pre_state", 32'(dbg_state), 32'(S_WAIT));
    chk("rw_pre_rdata", mem_rdata, 32'h7766_5544);
    tick();
    rst = 1'b0; mem_en = 1'b0; mem_wen = '0;
    @(negedge clk);
    chk("rw_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rw_valid", 32'(req_valid), 32'd0);
    chk("rw_write", 32'(req_write), 32'd0);
    chk("rw_strb", 32'(req_strb), 32'd0);
    chk("rw_addr", req_addr, 32'd0);
    chk("rw_wdata", req_wdata, 32'd0);
    chk("rw_rdata", mem_rdata, 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    tick();
    resp_valid = 1'b1; resp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rw_stray_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    chk("rw_stray_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("rw_stray_rdata", mem_rdata, 32'd0);
    tick();

    // Random reads and writes with random handshake delays
    for (int n = 0; n < 6; n++) begin
      logic [SW-1:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : SW'($urandom_range(1, 15));
      run_access({AW'($urandom) & 32'hFFFF_FFFC}, w, DW'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, TO - 1), DW'($urandom));
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
